// File: rtl/gtp_link_ctrl.sv
// GTP receive link bring-up: GT reset sequencing, comma-word alignment by bit-slip,
// lock/loss tracking over fixed windows, and a saturating re-init counter.
module gtp_link_ctrl #(
    parameter logic [15:0] ALIGN_WORD = 16'h50BC,
    parameter int unsigned WIN        = 256,
    parameter int unsigned LOCK_WINS  = 4,
    parameter int unsigned LOSS_WINS  = 4,
    parameter int unsigned SLIDE_GAP  = 32,
    parameter int unsigned MAX_SLIDES = 20,
    parameter int unsigned RST_CYCLES = 8,
    parameter int unsigned WAIT_TMO   = 65535
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        reset_done,
    input  logic [15:0] rx_data,
    input  logic        force_resync,
    output logic        gt_reset,
    output logic        rx_slide,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  relock_cnt
);

    localparam int unsigned TmrMax0 = (WAIT_TMO > RST_CYCLES) ? WAIT_TMO : RST_CYCLES;
    localparam int unsigned TmrMax  = (TmrMax0 > SLIDE_GAP) ? TmrMax0 : SLIDE_GAP;
    localparam int unsigned TmrW    = $clog2(TmrMax + 1);
    localparam int unsigned WinW    = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned GoodW   = $clog2(LOCK_WINS + 1);
    localparam int unsigned BadW    = $clog2(LOSS_WINS + 1);
    localparam int unsigned SlideW  = $clog2(MAX_SLIDES + 1);

    typedef enum logic [2:0] {
        StRst       = 3'd0,
        StWaitDone  = 3'd1,
        StAlign     = 3'd2,
        StSlideWait = 3'd3,
        StLocked    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              rd_meta_q, rd_s_q, match_q;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [WinW-1:0]   win_q, win_d;
    logic              hit_q, hit_d;
    logic [GoodW-1:0]  good_q, good_d;
    logic [BadW-1:0]   bad_q, bad_d;
    logic [SlideW-1:0] slide_q, slide_d;
    logic [7:0]        relock_q, relock_d;
    logic              gt_reset_q, rx_slide_q, link_up_q;
    logic              pulse_d, win_end, win_hit;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + TmrW'(1);
        win_d    = win_q;
        hit_d    = hit_q;
        good_d   = good_q;
        bad_d    = bad_q;
        slide_d  = slide_q;
        relock_d = relock_q;
        pulse_d  = 1'b0;
        win_end  = (win_q == WinW'(WIN - 1));
        // A match registered on the window's last cycle still belongs to that window.
        win_hit  = hit_q | match_q;

        if (state_q == StAlign || state_q == StLocked) begin
            win_d = win_end ? '0 : win_q + WinW'(1);
            hit_d = win_end ? 1'b0 : win_hit;
        end

        unique case (state_q)
            StRst: begin
                win_d   = '0;
                hit_d   = 1'b0;
                good_d  = '0;
                bad_d   = '0;
                slide_d = '0;
                if (tmr_q == TmrW'(RST_CYCLES - 1)) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (rd_s_q) begin
                    state_d = StAlign;
                    win_d   = '0;
                    hit_d   = 1'b0;
                end else if (tmr_q == TmrW'(WAIT_TMO - 1)) begin
                    state_d = StRst;
                end
            end
            StAlign: begin
                if (win_end) begin
                    if (win_hit) begin
                        good_d = good_q + GoodW'(1);
                        if (good_d == GoodW'(LOCK_WINS)) begin
                            state_d = StLocked;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d  = '0;
                        slide_d = slide_q + SlideW'(1);
                        if (slide_d == SlideW'(MAX_SLIDES)) begin
                            state_d = StRst;
                        end else begin
                            pulse_d = 1'b1;
                            state_d = StSlideWait;
                        end
                    end
                end
            end
            StSlideWait: begin
                // Pulse cycle plus SLIDE_GAP quiet cycles before the next window.
                if (tmr_q == TmrW'(SLIDE_GAP)) begin
                    state_d = StAlign;
                    win_d   = '0;
                    hit_d   = 1'b0;
                end
            end
            StLocked: begin
                if (win_end) begin
                    if (win_hit) begin
                        bad_d = '0;
                    end else begin
                        bad_d = bad_q + BadW'(1);
                        if (bad_d == BadW'(LOSS_WINS)) state_d = StRst;
                    end
                end
            end
            default: state_d = StRst;
        endcase

        if (!rd_s_q && (state_q == StAlign || state_q == StSlideWait || state_q == StLocked)) begin
            state_d = StWaitDone;
            pulse_d = 1'b0;
            win_d   = '0;
            hit_d   = 1'b0;
            good_d  = '0;
            bad_d   = '0;
            slide_d = '0;
        end

        if (force_resync && state_q != StRst) begin
            state_d = StRst;
            pulse_d = 1'b0;
        end

        if (state_d != state_q) tmr_d = '0;
        if (state_d == StRst && state_q != StRst && relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            rd_meta_q  <= 1'b0;
            rd_s_q     <= 1'b0;
            match_q    <= 1'b0;
            state_q    <= StRst;
            tmr_q      <= '0;
            win_q      <= '0;
            hit_q      <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
            slide_q    <= '0;
            relock_q   <= '0;
            gt_reset_q <= 1'b1;
            rx_slide_q <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            rd_meta_q  <= reset_done;
            rd_s_q     <= rd_meta_q;
            match_q    <= (rx_data == ALIGN_WORD);
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            hit_q      <= hit_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            slide_q    <= slide_d;
            relock_q   <= relock_d;
            gt_reset_q <= (state_d == StRst);
            rx_slide_q <= pulse_d;
            link_up_q  <= (state_d == StLocked);
        end
    end

    assign gt_reset   = gt_reset_q;
    assign rx_slide   = rx_slide_q;
    assign link_up    = link_up_q;
    assign state      = state_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_gtp_link_ctrl.sv
// Scenario bench for gtp_link_ctrl: expected per-cycle observations and rx_slide pulse
// times are queued when each scenario starts and consumed by a negedge monitor.
module tb_gtp_link_ctrl;

    localparam logic [15:0] AW = 16'h50BC;

    logic        rx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_done = 1'b0;
    logic [15:0] rx_data = 16'h0000;
    logic        force_resync = 1'b0;
    logic        gt_reset, rx_slide, link_up;
    logic [2:0]  state;
    logic [7:0]  relock_cnt;

    gtp_link_ctrl #(
        .ALIGN_WORD(AW),
        .WIN(16),
        .LOCK_WINS(2),
        .LOSS_WINS(2),
        .SLIDE_GAP(4),
        .MAX_SLIDES(3),
        .RST_CYCLES(4),
        .WAIT_TMO(65535)
    ) dut (
        .rx_clk(rx_clk),
        .reset(reset),
        .reset_done(reset_done),
        .rx_data(rx_data),
        .force_resync(force_resync),
        .gt_reset(gt_reset),
        .rx_slide(rx_slide),
        .link_up(link_up),
        .state(state),
        .relock_cnt(relock_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int unsigned cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        string       tag;
        int unsigned cyc;
        logic [2:0]  st;
        logic        lk;
        logic        gr;
        logic [7:0]  rel;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned slide_exp_q[$];
    exp_t        mon_e;
    logic        slide_prev = 1'b0;
    int unsigned t0 = 0;

    task automatic expect_at(input string tag, input int unsigned c, input logic [2:0] st,
                             input logic lk, input logic gr, input logic [7:0] rel);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.st  = st;
        e.lk  = lk;
        e.gr  = gr;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    always @(negedge rx_clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check_eq({mon_e.tag, ".cyc"}, cyc, mon_e.cyc);
            check_eq({mon_e.tag, ".state"}, 32'(state), 32'(mon_e.st));
            check_eq({mon_e.tag, ".link_up"}, 32'(link_up), 32'(mon_e.lk));
            check_eq({mon_e.tag, ".gt_reset"}, 32'(gt_reset), 32'(mon_e.gr));
            check_eq({mon_e.tag, ".relock"}, 32'(relock_cnt), 32'(mon_e.rel));
        end
        if (rx_slide) begin
            if (slide_exp_q.size() == 0) check_eq("slide.unexpected", cyc, 0);
            else check_eq("slide.cyc", cyc, slide_exp_q.pop_front());
            check_eq("slide.single", 32'(slide_prev), 0);
        end
        slide_prev = rx_slide;
    end

    function automatic logic [15:0] noise();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == AW) v = v ^ 16'h0001;
        return v;
    endfunction

    // mode 0: no alignment words; 1: one every 16 cycles; 2: only on the window-0 boundary
    task automatic drive_to(input int unsigned rel_end, input int mode);
        int unsigned rel;
        while (cyc - t0 < rel_end) begin
            @(negedge rx_clk);
            rel = cyc - t0;
            case (mode)
                1:       rx_data = (rel % 16 == 5) ? AW : noise();
                2:       rx_data = (rel == 27 || rel == 28) ? AW : noise();
                default: rx_data = noise();
            endcase
        end
    endtask

    task automatic start_scn(input string name);
        @(negedge rx_clk);
        reset        = 1'b1;
        reset_done   = 1'b0;
        force_resync = 1'b0;
        rx_data      = 16'h0000;
        repeat (2) @(negedge rx_clk);
        expect_at({name, ".in_reset"}, cyc + 1, 3'd0, 1'b0, 1'b1, 8'd0);
        @(negedge rx_clk);
        t0    = cyc;
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) expect_at({name, ".gt_rst"}, t0 + k, 3'd0, 1'b0, 1'b1, 8'd0);
        expect_at({name, ".to_wait"}, t0 + 4, 3'd1, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        // Bring-up then loss of alignment words.
        start_scn("bringup");
        expect_at("bringup.wait", t0 + 12, 3'd1, 1'b0, 1'b0, 8'd0);
        expect_at("bringup.align", t0 + 13, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("bringup.prelock", t0 + 44, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("bringup.lock", t0 + 45, 3'd4, 1'b1, 1'b0, 8'd0);
        expect_at("loss.miss1", t0 + 77, 3'd4, 1'b1, 1'b0, 8'd0);
        expect_at("loss.hold", t0 + 92, 3'd4, 1'b1, 1'b0, 8'd0);
        expect_at("loss.rst", t0 + 93, 3'd0, 1'b0, 1'b1, 8'd1);
        drive_to(10, 1);
        reset_done = 1'b1;
        drive_to(60, 1);
        drive_to(100, 0);

        // No alignment words: two slides then a GT reset.
        start_scn("slide");
        slide_exp_q.push_back(t0 + 29);
        slide_exp_q.push_back(t0 + 50);
        expect_at("slide.wait", t0 + 12, 3'd1, 1'b0, 1'b0, 8'd0);
        expect_at("slide.align", t0 + 13, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("slide.sw1", t0 + 29, 3'd3, 1'b0, 1'b0, 8'd0);
        expect_at("slide.gap_end", t0 + 33, 3'd3, 1'b0, 1'b0, 8'd0);
        expect_at("slide.realign", t0 + 34, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("slide.sw2", t0 + 50, 3'd3, 1'b0, 1'b0, 8'd0);
        expect_at("slide.last_win", t0 + 70, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("slide.gt_reset", t0 + 71, 3'd0, 1'b0, 1'b1, 8'd1);
        drive_to(10, 0);
        reset_done = 1'b1;
        drive_to(74, 0);

        // reset_done drop while locked.
        start_scn("rddrop");
        expect_at("rddrop.lock", t0 + 45, 3'd4, 1'b1, 1'b0, 8'd0);
        expect_at("rddrop.sync", t0 + 52, 3'd4, 1'b1, 1'b0, 8'd0);
        expect_at("rddrop.wait", t0 + 53, 3'd1, 1'b0, 1'b0, 8'd0);
        expect_at("rddrop.stay", t0 + 58, 3'd1, 1'b0, 1'b0, 8'd0);
        drive_to(10, 1);
        reset_done = 1'b1;
        drive_to(50, 1);
        reset_done = 1'b0;
        drive_to(60, 1);

        // Alignment words only around the first window boundary.
        start_scn("boundary");
        expect_at("boundary.align", t0 + 13, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("boundary.win0", t0 + 29, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("boundary.lock", t0 + 45, 3'd4, 1'b1, 1'b0, 8'd0);
        drive_to(10, 2);
        reset_done = 1'b1;
        drive_to(50, 2);

        // force_resync coinciding with a window-end miss.
        start_scn("force");
        expect_at("force.align", t0 + 13, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("force.pre", t0 + 28, 3'd2, 1'b0, 1'b0, 8'd0);
        expect_at("force.rst", t0 + 29, 3'd0, 1'b0, 1'b1, 8'd1);
        expect_at("force.rst_end", t0 + 32, 3'd0, 1'b0, 1'b1, 8'd1);
        expect_at("force.wait", t0 + 33, 3'd1, 1'b0, 1'b0, 8'd1);
        drive_to(10, 0);
        reset_done = 1'b1;
        drive_to(28, 0);
        force_resync = 1'b1;
        drive_to(29, 0);
        force_resync = 1'b0;
        drive_to(40, 0);

        repeat (2) @(negedge rx_clk);
        check_eq("exp_left", exp_q.size(), 0);
        check_eq("slide_left", slide_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
